// File: rtl/g_udp_tx_sched_if.sv
// Bus between the UDP TX scheduler, its payload sources and the transmit engine.
// fsm_state carries the scheduler state encoding for observation only.
interface g_udp_tx_sched_if #(
    parameter int NUM_REQ = 4
);
    // Source handshake: req[i] is a level held (with req_len slice i stable) until
    // the one-cycle ack[i] pulse; the source drops req[i] on the following cycle.
    // err[i] only ever pulses together with ack[i].
    logic [NUM_REQ-1:0]    req;
    logic [16*NUM_REQ-1:0] req_len;
    logic [NUM_REQ-1:0]    ack;
    logic [NUM_REQ-1:0]    err;
    logic [9*NUM_REQ-1:0]  src_rd_addr;
    logic [32*NUM_REQ-1:0] src_rd_data;
    logic [8:0]            eng_rd_addr;
    logic [31:0]           eng_rd_data;
    logic [15:0]           tx_data_length;
    logic [15:0]           tx_total_length;
    logic                  eng_start;
    logic                  eng_done;
    logic [NUM_REQ-1:0]    grant;
    logic                  busy;
    logic [2:0]            fsm_state;

    modport master (
        input  req, req_len, src_rd_data, eng_rd_addr, eng_done,
        output ack, err, src_rd_addr, eng_rd_data, tx_data_length, tx_total_length,
               eng_start, grant, busy, fsm_state
    );

    modport slave (
        output req, req_len, src_rd_data, eng_rd_addr, eng_done,
        input  ack, err, src_rd_addr, eng_rd_data, tx_data_length, tx_total_length,
               eng_start, grant, busy, fsm_state
    );
endinterface

// File: rtl/g_udp_tx_sched.sv
// Round-robin owner selection for the shared UDP/IP transmit engine: length
// latching, engine start, payload-RAM steering, completion timeout and inter-frame gap.
module g_udp_tx_sched #(
    parameter int NUM_REQ        = 4,
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MIN_PAYLOAD    = 18,
    parameter int MAX_PAYLOAD    = 1472
) (
    input  logic clk,
    input  logic reset_n,
    g_udp_tx_sched_if.master bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t               state;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        owner;
    logic [NUM_REQ-1:0]   grant_r;
    logic [NUM_REQ-1:0]   ack_r;
    logic [NUM_REQ-1:0]   err_r;
    logic                 eng_start_r;
    logic [15:0]          data_len_r;
    logic [15:0]          total_len_r;
    logic [TW-1:0]        timer;
    logic [GW-1:0]        gap_cnt;

    logic [2*NUM_REQ-1:0] req_rot;
    logic [PW-1:0]        win_off;
    logic [PW:0]          win_sum;
    logic [PW-1:0]        win_idx;
    logic [PW-1:0]        ptr_next;
    logic [NUM_REQ-1:0]   win_oh;
    logic                 win_found;
    logic [15:0]          cur_len;
    logic [15:0]          pad_len;
    logic                 len_bad;

    // Rotate the request vector so the pointer position lands at bit 0; the lowest
    // set bit is then the distance from the pointer to the winner.
    always_comb begin
        req_rot   = {bus.req, bus.req} >> ptr;
        win_off   = '0;
        win_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_off   = PW'(k);
                win_found = 1'b1;
            end
        end
        win_sum = {1'b0, ptr} + {1'b0, win_off};
        win_idx = (win_sum >= (PW+1)'(NUM_REQ)) ? PW'(win_sum - (PW+1)'(NUM_REQ)) : PW'(win_sum);
        ptr_next = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
        win_oh = '0;
        win_oh[win_idx] = 1'b1;
    end

    always_comb begin
        cur_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == PW'(i)) cur_len = bus.req_len[16*i +: 16];
        end
        pad_len = (cur_len < 16'(MIN_PAYLOAD)) ? 16'(MIN_PAYLOAD) : cur_len;
        len_bad = (cur_len == 16'd0) || (cur_len > 16'(MAX_PAYLOAD));
    end

    // Read steering is purely combinational so the engine keeps its native RAM latency.
    always_comb begin
        bus.src_rd_addr = '0;
        bus.eng_rd_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_r[i]) begin
                bus.src_rd_addr[9*i +: 9] = bus.eng_rd_addr;
                bus.eng_rd_data = bus.eng_rd_data | bus.src_rd_data[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            ptr         <= '0;
            owner       <= '0;
            grant_r     <= '0;
            ack_r       <= '0;
            err_r       <= '0;
            eng_start_r <= 1'b0;
            data_len_r  <= '0;
            total_len_r <= '0;
            timer       <= '0;
            gap_cnt     <= '0;
        end else begin
            ack_r       <= '0;
            err_r       <= '0;
            eng_start_r <= 1'b0;
            case (state)
                S_IDLE: if (|bus.req) state <= S_ARB;
                S_ARB: begin
                    if (win_found) begin
                        grant_r <= win_oh;
                        owner   <= win_idx;
                        ptr     <= ptr_next;
                        state   <= S_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (len_bad) begin
                        ack_r   <= grant_r;
                        err_r   <= grant_r;
                        grant_r <= '0;
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else begin
                        data_len_r  <= pad_len + 16'd8;
                        total_len_r <= pad_len + 16'd28;
                        eng_start_r <= 1'b1;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion on the timeout cycle still wins.
                    if (bus.eng_done) begin
                        ack_r   <= grant_r;
                        grant_r <= '0;
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        ack_r   <= grant_r;
                        err_r   <= grant_r;
                        grant_r <= '0;
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GW'(IFG_CYCLES - 1)) state <= S_IDLE;
                    else gap_cnt <= gap_cnt + GW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ack             = ack_r;
    assign bus.err             = err_r;
    assign bus.grant           = grant_r;
    assign bus.eng_start       = eng_start_r;
    assign bus.tx_data_length  = data_len_r;
    assign bus.tx_total_length = total_len_r;
    assign bus.busy            = (state != S_IDLE);
    assign bus.fsm_state       = state;
endmodule

// File: doc/g_udp_tx_sched.md
Name: g_udp_tx_sched

Overview:
- Round-robin scheduler that shares the single 1G UDP/IP transmit engine between NUM_REQ payload sources.
- For each frame it latches the winning source's payload length and derives the UDP data length and IP total length.
- It starts the engine and steers the engine's payload-RAM read port to the winning source's buffer.
- After the engine reports completion it enforces an inter-frame gap, then rearbitrates.

Parameters:
- NUM_REQ, 4, number of payload sources (2..8).
- IFG_CYCLES, 12, idle clocks inserted after eng_done before the next eng_start.
- TIMEOUT_CYCLES, 4096, max clocks to wait for eng_done before aborting.
- MIN_PAYLOAD, 18, minimum UDP payload bytes; shorter requests are padded up to this value.
- MAX_PAYLOAD, 1472, maximum UDP payload bytes; longer requests are rejected.

Ports:
- clk  in  1  e_rxc-domain clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-source frame request, level, held until ack.
- req_len  in  16*NUM_REQ  per-source payload byte count, slice i = [16i+15:16i], stable while req[i]=1.
- ack  out  NUM_REQ  one-cycle pulse to the source whose frame finished or was rejected.
- err  out  NUM_REQ  one-cycle pulse alongside ack when the frame was rejected or timed out.
- src_rd_addr  out  9*NUM_REQ  per-source buffer read address; only the granted slice is driven, others 0.
- src_rd_data  in  32*NUM_REQ  per-source buffer read data.
- eng_rd_addr  in  9  engine RAM read address.
- eng_rd_data  out  32  muxed read data to engine, 0 when nothing granted.
- tx_data_length  out  16  UDP length to engine, equal to padded payload + 8.
- tx_total_length  out  16  IP total length to engine, equal to padded payload + 28.
- eng_start  out  1  one-cycle start pulse to engine.
- eng_done  in  1  one-cycle pulse from engine at end of FCS.
- grant  out  NUM_REQ  one-hot current owner, 0 when idle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0. State is IDLE and the round-robin pointer is 0. Asserting reset mid-frame aborts immediately with no ack.
- States are IDLE, ARB, LOAD, START, WAIT, GAP.
- IDLE: goes to ARB when any req bit is high.
- ARB (1 cycle): selects the first set req at or after the pointer, wrapping modulo NUM_REQ, and registers grant one-hot.
  - The pointer updates to winner+1 (mod NUM_REQ) at the moment of selection.
  - If req has dropped to 0 by ARB, return to IDLE with no grant.
- LOAD (1 cycle): latch L = req_len slice of the winner.
  - If L=0 or L>MAX_PAYLOAD: pulse ack and err for the winner, clear grant, go to GAP. No eng_start is issued.
  - Otherwise P = max(L, MIN_PAYLOAD). tx_data_length = P+8 and tx_total_length = P+28, both 16-bit with no overflow possible within the limits.
  - Both lengths hold until the next LOAD.
- START: eng_start=1 for exactly one cycle, then go to WAIT.
- WAIT: eng_rd_data and src_rd_addr follow the grant combinationally, with no added latency; the engine sees its RAM timing unchanged.
  - On eng_done: pulse ack for the winner the next cycle, clear grant, go to GAP.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 with no eng_done: pulse ack and err, clear grant, go to GAP.
  - An eng_done arriving on the same cycle as the timeout counts as success.
- GAP: count IFG_CYCLES clocks, then go to IDLE. req is not sampled during GAP.
- A source must drop req on the cycle after ack. If req stays high, that source is re-served only after the pointer rotates past the other sources.
- An eng_done arriving outside WAIT is ignored.
- With grant=0, src_rd_addr is all 0 and eng_rd_data = 0.

Test Plan:
- Single request: req=4'b0010, len=100 -> grant=0010 and eng_start once. tx_data_length=108, tx_total_length=128. ack[1] pulses 1 cycle after eng_done. No eng_start for 12 cycles after eng_done.
- Fairness: all four req held high -> service order 0,1,2,3,0.
  - Reset, then req=4'b1000 first -> source 3 served, then 0.
- Padding and reject: len=5 -> lengths 26/46. len=0 -> ack+err, no eng_start. len=1473 -> ack+err. len=1472 -> lengths 1480/1500.
- Timeout: eng_done withheld -> ack+err exactly 4096 cycles after entering WAIT.
  - eng_done on the timeout cycle -> ack without err.
- Datapath mux: while source 2 is granted, eng_rd_addr=0x1A5 appears on slice 2 of src_rd_addr only, and eng_rd_data = src_rd_data slice 2 in the same cycle.
- Reset in WAIT: reset_n low for 1 cycle -> all outputs 0 with no ack. After release, a pending req is re-arbitrated starting at source 0.
